// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: MSI snoop/arbitration controller between two dcaches and one RAM port
module coherence_bus_ctrl #(
  parameter int BLK_WORDS    = 2,
  parameter int SNOOP_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  input  logic [1:0]       cctrans,
  input  logic [1:0]       ccwrite,
  output logic [1:0]       dwait,
  output logic [1:0][31:0] dload,
  output logic [1:0]       ccwait,
  output logic [1:0]       ccinv,
  output logic [1:0][31:0] ccsnoopaddr,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic             ramready
);
  localparam int BW = BLK_WORDS > 1 ? $clog2(BLK_WORDS) : 1;
  localparam int SW = SNOOP_CYCLES > 1 ? $clog2(SNOOP_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, WB, SNOOP, C2C, RAMLD} state_t;
  state_t state_q, state_d;
  logic r_q, r_d, prio_q, prio_d, inv_q, inv_d;
  logic [31:0] addr_q, addr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [SW-1:0] snp_q, snp_d;
  logic [1:0] req;
  logic g, s, last_beat;
  assign req = cctrans | dWEN;
  assign g = (req == 2'b11) ? prio_q : req[1];
  assign s = ~r_q;
  assign last_beat = beat_q == BW'(BLK_WORDS - 1);
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) begin
      state_q <= IDLE;
      r_q     <= 1'b0;
      prio_q  <= 1'b0;
      inv_q   <= 1'b0;
      addr_q  <= '0;
      beat_q  <= '0;
      snp_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      prio_q  <= prio_d;
      inv_q   <= inv_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      snp_q   <= snp_d;
    end
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    prio_d      = prio_q;
    inv_d       = inv_q;
    addr_d      = addr_q;
    beat_d      = beat_q;
    snp_d       = snp_q;
    dwait       = 2'b11;
    dload       = '0;
    ccwait      = 2'b00;
    ccinv       = 2'b00;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state_q)
      IDLE: if (|req) begin
        r_d    = g;
        prio_d = ~g;
        if (cctrans[g]) begin
          addr_d  = {daddr[g][31:3], 3'b000};
          inv_d   = ccwrite[g];
          snp_d   = '0;
          state_d = SNOOP;
        end else state_d = WB;
      end
      WB: begin
        ramWEN     = 1'b1;
        ramaddr    = daddr[r_q];
        ramstore   = dstore[r_q];
        dwait[r_q] = ~ramready;
      end
      SNOOP: begin
        ccwait[s]      = 1'b1;
        ccinv[s]       = inv_q;
        ccsnoopaddr[s] = addr_q;
        if (snp_q == SW'(SNOOP_CYCLES - 1)) state_d = ccwrite[s] ? C2C : dREN[r_q] ? RAMLD : IDLE;
        else snp_d = snp_q + 1'b1;
      end
      C2C: begin
        ccwait[s]      = 1'b1;
        ccinv[s]       = inv_q;
        ccsnoopaddr[s] = addr_q;
        ramWEN         = 1'b1;
        ramaddr        = daddr[s];
        ramstore       = dstore[s];
        dload[r_q]     = dstore[s];
        dwait          = {2{~ramready}};
      end
      RAMLD: begin
        ramREN     = 1'b1;
        ramaddr    = daddr[r_q];
        dload[r_q] = ramload;
        dwait[r_q] = ~ramready;
      end
      default: state_d = IDLE;
    endcase
    // beats only count while a RAM transfer is actually in flight
    if (ramready && state_q inside {WB, C2C, RAMLD}) begin
      beat_d = last_beat ? '0 : beat_q + 1'b1;
      if (last_beat) state_d = IDLE;
    end
  end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb_coherence_bus_ctrl: scoreboard bench with directed MSI transactions against coherence_bus_ctrl
module tb_coherence_bus_ctrl;
  logic CLK = 1'b0, nRST = 1'b0;
  logic [1:0] dREN = '0, dWEN = '0, cctrans = '0, ccwrite = '0;
  logic [1:0][31:0] daddr = '0, dstore = '0;
  logic [1:0] dwait, ccwait, ccinv;
  logic [1:0][31:0] dload, ccsnoopaddr;
  logic ramREN, ramWEN, ramready = 1'b0;
  logic [31:0] ramaddr, ramstore, ramload = '0;
  typedef struct {logic [31:0] dw, lm, ld, ren, wen, a, st;} beat_t;
  typedef struct {logic [31:0] w, inv, a, len;} snoop_t;
  beat_t bq[$];
  snoop_t sq[$];
  beat_t eb;
  snoop_t es;
  int n_cmp = 0, n_bad = 0;
  logic [1:0] dw_prev = 2'b11;
  logic [31:0] base[2];
  logic [31:0] dat[2][2];
  int bc[2], nw[2];
  logic [1:0] act = '0;
  logic ph = 1'b0;
  logic [1:0] pcw = '0, cw_c = '0, ci_c = '0;
  logic [31:0] ca_c = '0;
  int len_c = 0;

  always #5 CLK = ~CLK;

  coherence_bus_ctrl #(.BLK_WORDS(2), .SNOOP_CYCLES(1)) dut (
    .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .cctrans(cctrans), .ccwrite(ccwrite), .dwait(dwait), .dload(dload), .ccwait(ccwait),
    .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramready(ramready)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_dwait"}, 32'(dwait), 32'h3);
    chk({p, "_ccwait"}, 32'(ccwait), 32'h0);
    chk({p, "_ccinv"}, 32'(ccinv), 32'h0);
    chk({p, "_ramctl"}, 32'({ramREN, ramWEN}), 32'h0);
    chk({p, "_ramaddr"}, ramaddr, 32'h0);
    chk({p, "_ramstore"}, ramstore, 32'h0);
    chk({p, "_dload0"}, dload[0], 32'h0);
    chk({p, "_dload1"}, dload[1], 32'h0);
    chk({p, "_snpaddr0"}, ccsnoopaddr[0], 32'h0);
    chk({p, "_snpaddr1"}, ccsnoopaddr[1], 32'h0);
  endtask

  task automatic pb(input logic [31:0] dw, lm, ld, ren, wen, a, st);
    bq.push_back('{dw, lm, ld, ren, wen, a, st});
  endtask

  task automatic ps(input logic [31:0] w, inv, a, len);
    sq.push_back('{w, inv, a, len});
  endtask

  task automatic setc(input int i, input logic [31:0] b, d0, d1);
    base[i] = b;
    dat[i][0] = d0;
    dat[i][1] = d1;
    bc[i] = 0;
    daddr[i] = b;
    dstore[i] = d0;
  endtask

  // each core steps its address/data after every accepted beat, like a dcache would
  task automatic tick();
    @(negedge CLK);
    for (int i = 0; i < 2; i++)
      if (!dw_prev[i]) begin
        bc[i]++;
        daddr[i] = base[i] + 32'(4 * bc[i]);
        dstore[i] = dat[i][bc[i] % 2];
      end
  endtask

  task automatic run();
    int t = 0;
    while (act != 0 && t < 200) begin
      tick();
      t++;
      for (int i = 0; i < 2; i++)
        if (act[i] && bc[i] == 2) begin
          nw[i]--;
          if (nw[i] == 0) begin
            act[i] = 1'b0;
            cctrans[i] = 1'b0;
            dWEN[i] = 1'b0;
            dREN[i] = 1'b0;
            ccwrite[i] = 1'b0;
          end else begin
            bc[i] = 0;
            daddr[i] = base[i];
            dstore[i] = dat[i][0];
          end
        end
    end
    n_cmp++;
    if (act != 0) begin
      n_bad++;
      $display("FAIL run_timeout: %0d cycles, still active %b, required 00", t, act);
      act = '0;
      cctrans = '0;
      dWEN = '0;
      dREN = '0;
      ccwrite = '0;
    end
  endtask

  // RAM model: ready on every second cycle of an active access
  initial forever begin
    @(negedge CLK);
    #1;
    if (ramREN || ramWEN) begin
      ph = ~ph;
      ramready = !ph;
    end else begin
      ph = 1'b0;
      ramready = 1'b0;
    end
    ramload = (ramaddr == 32'h100) ? 32'hA : (ramaddr == 32'h104) ? 32'hB : ~ramaddr;
  end

  // monitor: pops expected beats and snoops as the DUT presents them
  initial forever begin
    @(negedge CLK);
    #3;
    dw_prev = dwait;
    chk("ram_excl", 32'(ramREN & ramWEN), 32'h0);
    if (ramready && (ramREN || ramWEN)) begin
      if (bq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL beat_unexpected: got addr %h store %h, required no beat", ramaddr, ramstore);
      end else begin
        eb = bq.pop_front();
        chk("beat_dwait", 32'(dwait), eb.dw);
        chk("beat_ramREN", 32'(ramREN), eb.ren);
        chk("beat_ramWEN", 32'(ramWEN), eb.wen);
        chk("beat_ramaddr", ramaddr, eb.a);
        if (eb.wen != 0) chk("beat_ramstore", ramstore, eb.st);
        if (eb.lm == 1) begin
          chk("beat_dload0", dload[0], eb.ld);
          chk("beat_dload1_zero", dload[1], 32'h0);
        end else if (eb.lm == 2) begin
          chk("beat_dload1", dload[1], eb.ld);
          chk("beat_dload0_zero", dload[0], 32'h0);
        end
      end
    end else chk("dwait_idle", 32'(dwait), 32'h3);
    if (ccwait != 0 && pcw == 0) begin
      cw_c = ccwait;
      ci_c = ccinv;
      ca_c = ccwait[0] ? ccsnoopaddr[0] : ccsnoopaddr[1];
      len_c = 1;
    end else if (ccwait != 0) len_c++;
    else if (pcw != 0) begin
      if (sq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL snoop_unexpected: got ccwait %b, required no snoop", cw_c);
      end else begin
        es = sq.pop_front();
        chk("snoop_ccwait", 32'(cw_c), es.w);
        chk("snoop_ccinv", 32'(ci_c), es.inv);
        chk("snoop_addr", ca_c, es.a);
        chk("snoop_len", 32'(len_c), es.len);
      end
    end
    pcw = ccwait;
  end

  initial begin
    repeat (2) @(negedge CLK);
    #4;
    chk_reset("reset");
    @(negedge CLK);
    nRST = 1'b1;
    // simultaneous write-backs held continuously: core0 first, then alternating
    setc(0, 32'h1000, 32'hC00, 32'hC01);
    setc(1, 32'h2000, 32'hC10, 32'hC11);
    for (int k = 0; k < 2; k++) begin
      pb(2'b10, 0, 0, 0, 1, 32'h1000, 32'hC00);
      pb(2'b10, 0, 0, 0, 1, 32'h1004, 32'hC01);
      pb(2'b01, 0, 0, 0, 1, 32'h2000, 32'hC10);
      pb(2'b01, 0, 0, 0, 1, 32'h2004, 32'hC11);
    end
    nw = '{2, 2};
    dWEN = 2'b11;
    act = 2'b11;
    run();
    tick();
    // core0 read miss, peer not Modified: fill from RAM
    setc(0, 32'h100, 0, 0);
    setc(1, 32'h900, 0, 0);
    ps(2'b10, 2'b00, 32'h100, 1);
    pb(2'b10, 1, 32'hA, 1, 0, 32'h100, 0);
    pb(2'b10, 1, 32'hB, 1, 0, 32'h104, 0);
    cctrans[0] = 1'b1;
    dREN[0] = 1'b1;
    nw[0] = 1;
    act = 2'b01;
    run();
    tick();
    // core1 write miss, core0 holds M: cache-to-cache with write-back
    setc(0, 32'h200, 32'h11, 32'h22);
    setc(1, 32'h200, 0, 0);
    ccwrite[0] = 1'b1;
    ps(2'b01, 2'b01, 32'h200, 5);
    pb(2'b00, 2, 32'h11, 0, 1, 32'h200, 32'h11);
    pb(2'b00, 2, 32'h22, 0, 1, 32'h204, 32'h22);
    cctrans[1] = 1'b1;
    ccwrite[1] = 1'b1;
    dREN[1] = 1'b1;
    nw[1] = 1;
    act = 2'b10;
    run();
    ccwrite[0] = 1'b0;
    tick();
    // S->M upgrade on an unaligned word: snoop only, no RAM traffic
    setc(0, 32'h30C, 0, 0);
    ps(2'b10, 2'b10, 32'h308, 1);
    cctrans[0] = 1'b1;
    ccwrite[0] = 1'b1;
    tick();
    cctrans[0] = 1'b0;
    ccwrite[0] = 1'b0;
    repeat (4) tick();
    // reset during the second beat of a cache-to-cache transfer
    setc(0, 32'h300, 0, 0);
    setc(1, 32'h300, 32'h33, 32'h44);
    ccwrite[1] = 1'b1;
    ps(2'b10, 2'b10, 32'h300, 3);
    pb(2'b00, 1, 32'h33, 0, 1, 32'h300, 32'h33);
    cctrans[0] = 1'b1;
    ccwrite[0] = 1'b1;
    dREN[0] = 1'b1;
    begin
      int t = 0;
      while (bc[0] == 0 && t < 50) begin
        tick();
        t++;
      end
      chk("c2c_first_beat_seen", 32'(bc[0]), 32'h1);
    end
    nRST = 1'b0;
    cctrans = '0;
    ccwrite = '0;
    dREN = '0;
    #2;
    chk_reset("midrst");
    tick();
    nRST = 1'b1;
    tick();
    // fresh write-back must take exactly BLK_WORDS beats
    setc(1, 32'h400, 32'h55, 32'h66);
    pb(2'b01, 0, 0, 0, 1, 32'h400, 32'h55);
    pb(2'b01, 0, 0, 0, 1, 32'h404, 32'h66);
    dWEN[1] = 1'b1;
    nw[1] = 1;
    act = 2'b10;
    run();
    repeat (6) tick();
    n_cmp++;
    if (bq.size() != 0 || sq.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: %0d beats %0d snoops outstanding, required 0", bq.size(), sq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
- Bus-side responder for the MSI snooping protocol driven by the two per-core data caches.
- Arbitrates coherence transactions (cctrans/ccwrite) and plain write-backs (dWEN) from two dcaches.
- Snoops and, on a write, invalidates the other cache; sources fills from RAM or from a Modified peer.
- Sits between the two dcaches and the single RAM port.

Parameters:
- BLK_WORDS, 2, words per cache block; transfers complete after this many RAM beats.
- SNOOP_CYCLES, 1, cycles ccwait is held before the snooper's ccwrite is sampled.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- dREN  in  2  per-core block-fill read request
- dWEN  in  2  per-core write-back / snoop-flush write request
- daddr  in  2x32  per-core word address
- dstore  in  2x32  per-core store data
- cctrans  in  2  per-core coherence transaction request
- ccwrite  in  2  requester: wants M; snooper: holds block in M
- dwait  out  2  per-core wait; low for one cycle = beat accepted
- dload  out  2x32  per-core fill data
- ccwait  out  2  snoop in progress for that core
- ccinv  out  2  snooped core must invalidate
- ccsnoopaddr  out  2x32  snoop address for that core
- ramREN  out  1  RAM read
- ramWEN  out  1  RAM write
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramready  in  1  RAM beat complete this cycle

Behaviour:
- Reset (nRST low, async): state IDLE, dwait=2'b11, ccwait=0, ccinv=0, ccsnoopaddr=0, dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0, beat counter=0, rr priority bit=0 (core 0 first). Reset mid-transaction abandons it; no partial state survives.
- Request of core i: req[i] = cctrans[i] | dWEN[i].
- Grant: the requesting core if only one requests; if both, core != last granted, then last updates.
- Requester r, snooper s = ~r.
- States: IDLE, WB, SNOOP, C2C, RAMLD.
- IDLE:
  - no req -> stay IDLE.
  - granted core has dWEN & ~cctrans -> WB.
  - granted core has cctrans -> latch {daddr[r][31:3],3'b0} and ccwrite[r], then SNOOP.
- WB: ramWEN=1, ramaddr=daddr[r], ramstore=dstore[r]; dwait[r]=~ramready. Each ramready increments the beat counter; at BLK_WORDS beats clear the counter -> IDLE.
- SNOOP: ccwait[s]=1, ccsnoopaddr[s]=latched address, ccinv[s]=latched ccwrite[r]. After SNOOP_CYCLES, sample ccwrite[s]:
  - ccwrite[s]=1 -> C2C; ccwait[s] stays 1.
  - else dREN[r]=1 -> RAMLD; ccwait[s] drops.
  - else (S->M upgrade, no data) -> IDLE; ccwait[s] drops.
- C2C (Modified peer supplies data):
  - ccwait[s]=1, ccinv[s] as latched.
  - ramWEN=1, ramaddr=daddr[s], ramstore=dstore[s].
  - dload[r]=dstore[s].
  - dwait[r]=dwait[s]=~ramready.
  - Counts BLK_WORDS beats -> IDLE; ccwait[s] low the cycle after the last beat.
- RAMLD: ramREN=1, ramaddr=daddr[r], dload[r]=ramload, dwait[r]=~ramready. Counts BLK_WORDS beats -> IDLE.
- Output rules:
  - ramREN and ramWEN are never both 1.
  - A non-granted core always sees dwait=1, even when it is requesting.
  - dload of the non-requester is 0.
- ramready while ramREN=ramWEN=0: ignored.
- Beat counter wraps to 0 exactly at BLK_WORDS. It advances only on ramready in WB/C2C/RAMLD.
- Request dropped mid-transfer: not supported. Once a transfer starts, the controller holds state until BLK_WORDS beats complete.
- Both cores cctrans to the same block in the same cycle: fully serialized by the grant. The loser is snooped by the winner's transaction first.
- Latency: grant in IDLE at cycle 0; SNOOP occupies cycles 1..SNOOP_CYCLES; first data beat is presented the cycle after SNOOP ends.

Test Plan:
- Core0 cctrans=1, ccwrite=0, dREN=1, daddr=0x100; ccwrite[1]=0; ramready every 2nd cycle; RAM returns 0xA, 0xB -> ccwait[1] 1 cycle, ccinv[1]=0, ccsnoopaddr[1]=0x100; dload[0]=0xA then 0xB with dwait[0] low on each ramready; then IDLE.
- Core1 cctrans=1, ccwrite=1, daddr=0x200; core0 answers ccwrite[0]=1 with dstore 0x11, 0x22 -> ccinv[0]=1; ramWEN writes 0x11@0x200 and 0x22@0x204; dload[1] mirrors the data; dwait[0] and dwait[1] low together on each ramready.
- Upgrade: core0 cctrans=1, ccwrite=1, dREN=0, ccwrite[1]=0 -> ccwait[1]=1 and ccinv[1]=1 for 1 cycle; no RAM activity; back to IDLE.
- Both cores assert dWEN in the same cycle after reset -> core0 served first (2 RAM writes), then core1; dwait[1] stays 1 throughout core0's write-back.
- Alternating requests from both cores held continuously -> grants alternate 0,1,0,1.
- nRST asserted during the second beat of C2C -> all outputs return to reset values immediately; the next request starts from IDLE with beat counter 0.
